alu_iter_exec: RTL and testbench



---
 rtl/alu_iter_exec.sv | 180 ++++++++++++++++++
 tb/tb_alu_iter_exec.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// Multi-cycle execute unit fed by the ALU-control decoder.
// Single-cycle ops resolve on the acceptance edge. Shifts iterate
// SHIFT_STEP bit positions per cycle through a narrow shifter.
// Results are held under a valid/ready handshake.
module alu_iter_exec #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  // Shift-amount width, per-iteration step width and the step as a counter-sized constant.
  localparam int AMT_W = $clog2(WIDTH);
  localparam int KW    = $clog2(SHIFT_STEP) + 1;
  localparam logic [AMT_W:0] STEP_L = (AMT_W+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [3:0]         op_p1;
  logic [WIDTH-1:0]   wrk_p1;
  logic [AMT_W-1:0]   cnt_p1;

  logic [AMT_W-1:0]   amt_in;
  logic [AMT_W:0]     k_full;
  logic [AMT_W-1:0]   cnt_nxt;
  logic [WIDTH-1:0]   wrk_nxt;
  logic [WIDTH-1:0]   alu_res;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Everything except shifts; unlisted codes fall back to ADD like the decoder.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLT:  r = WIDTH'(sa < sb);
      OP_SLTU: r = WIDTH'(a < b);
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Narrow shifter: only stages for the bits of k up to SHIFT_STEP exist.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       op,
                                                 input logic [KW-1:0]    k);
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] rs;
    r = v;
    for (int j = 0; j < KW; j++) begin
      if (k[j]) begin
        case (op)
          OP_SLL:  r = r << (1 << j);
          OP_SRL:  r = r >> (1 << j);
          default: begin
            rs = r;
            rs = rs >>> (1 << j);
            r  = rs;
          end
        endcase
      end
    end
    return r;
  endfunction

  // Step size for this iteration, next counter/working value, and the one-cycle result.
  always_comb begin
    amt_in  = SrcB[AMT_W-1:0];
    k_full  = ({1'b0, cnt_p1} < STEP_L) ? {1'b0, cnt_p1} : STEP_L;
    cnt_nxt = cnt_p1 - k_full[AMT_W-1:0];
    wrk_nxt = shift_by(wrk_p1, op_p1, k_full[KW-1:0]);
    alu_res = alu_op(ALUCtrl, SrcA, SrcB);
  end

  // Control FSM with registered handshake outputs, result and shift counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      cnt_p1    <= '0;
    end else begin
      case (state)
        // ---- IDLE -> accept: resolve now or start iterating ----
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift(ALUCtrl) && (amt_in != '0)) begin
              cnt_p1 <= amt_in;
              state  <= SHIFT;
            end else if (is_shift(ALUCtrl)) begin
              ALUResult <= SrcA;
              Zero      <= (SrcA == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              ALUResult <= alu_res;
              Zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        // ---- SHIFT -> one step per cycle; publish on the step that empties the counter ----
        SHIFT: begin
          cnt_p1 <= cnt_nxt;
          if (cnt_nxt == '0) begin
            ALUResult <= wrk_nxt;
            Zero      <= (wrk_nxt == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        // ---- DONE -> hold result until the consumer takes it ----
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Operand capture and working shift register; pure data, left unreset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && in_valid) begin
      op_p1  <= ALUCtrl;
      wrk_p1 <= SrcA;
    end else if (state == SHIFT) begin
      wrk_p1 <= wrk_nxt;
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec (WIDTH=32, SHIFT_STEP=1).
module tb_alu_iter_exec;

  localparam int W    = 32;
  localparam int STEP = 1;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] XOR_ = 4'b0010;
  localparam logic [3:0] OR_  = 4'b0011;
  localparam logic [3:0] AND_ = 4'b0100;
  localparam logic [3:0] SLL  = 4'b0101;
  localparam logic [3:0] SRL  = 4'b0110;
  localparam logic [3:0] SRA  = 4'b0111;
  localparam logic [3:0] SLT  = 4'b1000;
  localparam logic [3:0] SLTU = 4'b1001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUCtrl;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;

  always #5 clk = ~clk;

  alu_iter_exec #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtrl(ALUCtrl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   amt;
    amt   = int'(b[4:0]);
    e.lat = 1;
    case (op)
      SUB:  e.res = a - b;
      XOR_: e.res = a ^ b;
      OR_:  e.res = a | b;
      AND_: e.res = a & b;
      SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      SLL:  e.res = a << amt;
      SRL:  e.res = a >> amt;
      SRA:  e.res = $signed(a) >>> amt;
      default: e.res = a + b;
    endcase
    if ((op == SLL || op == SRL || op == SRA) && amt > 0)
      e.lat = (amt + STEP - 1) / STEP + 1;
    e.z = (e.res == 0);
    return e;
  endfunction

  // Issue one op, scramble inputs after acceptance, then collect the result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ":in_ready_idle"}, in_ready, 1);
    ALUCtrl   = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    ALUCtrl  = 4'($urandom);
    SrcA     = $urandom;
    SrcB     = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      check({tag, ":in_ready_busy"}, in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check({tag, ":latency"}, cyc, e.lat);
    check({tag, ":result"}, ALUResult, e.res);
    check({tag, ":zero"}, Zero, e.z);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      SrcA     = $urandom;
      @(negedge clk);
      check({tag, ":hold_valid"}, out_valid, 1);
      check({tag, ":hold_result"}, ALUResult, e.res);
      check({tag, ":hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":drain_valid"}, out_valid, 0);
    check({tag, ":back_idle"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] ops[10];
    ops = '{ADD, SUB, XOR_, OR_, AND_, SLL, SRL, SRA, SLT, SLTU};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUCtrl = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst:in_ready", in_ready, 1);
    check("rst:out_valid", out_valid, 0);
    check("rst:result", ALUResult, 0);
    check("rst:zero", Zero, 1);

    run_op("add5_7", ADD, 32'd5, 32'd7, 0);
    run_op("sub3_3", SUB, 32'd3, 32'd3, 0);
    run_op("sub0_1", SUB, 32'd0, 32'd1, 0);
    run_op("sra4", SRA, 32'h8000_0000, 32'd4, 0);
    run_op("sll3", SLL, 32'd1, 32'h23, 0);
    run_op("slt", SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("srl0", SRL, 32'h1234_5678, 32'h40, 0);
    run_op("sll31", SLL, 32'h0000_0003, 32'd31, 0);
    run_op("sra31", SRA, 32'h8000_0001, 32'd31, 0);
    run_op("xor_eq", XOR_, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    run_op("and", AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op("undef", 4'b1100, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("or_bp", OR_, 32'hF0, 32'h0F, 3);

    // Abort an in-flight shift with reset.
    ALUCtrl = SRL; SrcA = 32'hDEAD_BEEF; SrcB = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort:busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort:out_valid", out_valid, 0);
    check("abort:in_ready", in_ready, 1);
    check("abort:result", ALUResult, 0);
    check("abort:zero", Zero, 1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("abort:no_pulse", out_valid, 0);
    end
    run_op("add1_1", ADD, 32'd1, 32'd1, 0);

    for (int i = 0; i < 20; i++)
      run_op("rand", ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, 2));

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
